// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus broadcast arbiter.
// Default bus widths, functional-unit source indices and the bus entry layout.
package cdb_pkg;

    localparam int CDB_WIDTH = 31;
    localparam int CDB_ROB   = 2;

    localparam int SRC_ALU    = 0;
    localparam int SRC_BRANCH = 1;
    localparam int SRC_MEM    = 2;

    typedef struct packed {
        logic [CDB_ROB:0]          rob;
        logic signed [CDB_WIDTH:0] result;
    } cdb_entry_t;

    // Single-step modulo for round-robin indices; idx is always below 2*n.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-unit result buffer: DEPTH-entry circular FIFO with occupancy count and flush.
// Push is ignored when full, pop is ignored when empty, and flush overrides both.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int W     = 35,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH)) && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// Common data bus producer: buffers functional-unit results and broadcasts one per cycle
// under round-robin arbitration. Optional same-cycle bypass of empty buffers: CDB_BYPASS_EN.
module cdb_broadcast_arbiter
    import cdb_pkg::*;
#(
    parameter int WIDTH = CDB_WIDTH,
    parameter int ROB   = CDB_ROB,
    parameter int SRC   = 3,
    parameter int DEPTH = 2,
    localparam int SRC_W = (SRC > 1) ? $clog2(SRC) : 1
) (
    input  logic                     clk,
    input  logic                     globalResetN,
    input  logic                     clear,
    input  logic                     validCommit,
    input  logic [SRC-1:0]           unitValid,
    input  logic [SRC*(ROB+1)-1:0]   unitRob,
    input  logic [SRC*(WIDTH+1)-1:0] unitResult,
    output logic [SRC-1:0]           unitReady,
    output logic                     validBroadcast,
    output logic [ROB:0]             robEntry,
    output logic signed [WIDTH:0]    result,
    output logic [SRC_W-1:0]         broadcastSrc
);

    localparam int ENT_W = ROB + WIDTH + 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 flush;
    logic [ENT_W-1:0]     in_ent [SRC];
    logic [ENT_W-1:0]     head   [SRC];
    logic [CNT_W-1:0]     cnt    [SRC];
    logic [SRC-1:0]       nonempty, cand, push, pop;

    logic                 win_found;
    logic [SRC_W-1:0]     win_idx, probe;
    logic [ENT_W-1:0]     win_ent;

    logic                 valid_q, valid_d;
    logic [ROB:0]         rob_q, rob_d;
    logic signed [WIDTH:0] res_q, res_d;
    logic [SRC_W-1:0]     src_q, src_d;
    logic [SRC_W-1:0]     rr_q, rr_d;

    assign flush = clear & validCommit;

    // Handshake: a unit's result transfers on any edge where unitValid[i] & unitReady[i];
    // ready depends only on registered occupancy and flush, and a unit holds its
    // valid/data stable while ready is low.
    for (genvar g = 0; g < SRC; g++) begin : g_src
        assign in_ent[g]    = {unitRob[g*(ROB+1) +: ROB+1], unitResult[g*(WIDTH+1) +: WIDTH+1]};
        assign nonempty[g]  = (cnt[g] != '0);
        assign unitReady[g] = (cnt[g] < CNT_W'(DEPTH)) && !flush;

        cdb_src_fifo #(
            .W     (ENT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (globalResetN),
            .flush_i (flush),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .data_i  (in_ent[g]),
            .head_o  (head[g]),
            .count_o (cnt[g])
        );
    end

`ifdef CDB_BYPASS_EN
    assign cand = nonempty | (unitValid & unitReady);
`else
    assign cand = nonempty;
`endif

    // Descending scan: the last hit is the first candidate at or after rr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int k = SRC - 1; k >= 0; k--) begin
            probe = SRC_W'(rr_wrap(int'(rr_q) + k, SRC));
            if (cand[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    always_comb begin
        win_ent = head[win_idx];
`ifdef CDB_BYPASS_EN
        if (!nonempty[win_idx]) win_ent = in_ent[win_idx];
`endif
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < SRC; i++) begin
            push[i] = unitValid[i] & unitReady[i];
            pop[i]  = win_found & (win_idx == SRC_W'(i)) & nonempty[i] & ~flush;
`ifdef CDB_BYPASS_EN
            // A bypass winner goes straight to the bus and never occupies its buffer.
            if (win_found && (win_idx == SRC_W'(i)) && !nonempty[i]) push[i] = 1'b0;
`endif
        end
    end

    always_comb begin
        valid_d = 1'b0;
        rob_d   = rob_q;
        res_d   = res_q;
        src_d   = src_q;
        rr_d    = rr_q;
        if (win_found && !flush) begin
            valid_d = 1'b1;
            rob_d   = win_ent[ENT_W-1 -: ROB+1];
            res_d   = win_ent[WIDTH:0];
            src_d   = win_idx;
            rr_d    = (win_idx == SRC_W'(SRC - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge globalResetN) begin
        if (!globalResetN) begin
            valid_q <= 1'b0;
            rob_q   <= '0;
            res_q   <= '0;
            src_q   <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rob_q   <= rob_d;
            res_q   <= res_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

    assign validBroadcast = valid_q;
    assign robEntry       = rob_q;
    assign result         = res_q;
    assign broadcastSrc   = src_q;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Bench for cdb_broadcast_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with flushes.
`timescale 1ns/1ps
module tb_cdb_broadcast_arbiter;
    import cdb_pkg::*;

    localparam int SRC   = 3;
    localparam int DEPTH = 2;
    localparam int WIDTH = CDB_WIDTH;
    localparam int ROB   = CDB_ROB;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     globalResetN;
    logic                     clear;
    logic                     validCommit;
    logic [SRC-1:0]           unitValid;
    logic [SRC*(ROB+1)-1:0]   unitRob;
    logic [SRC*(WIDTH+1)-1:0] unitResult;
    logic [SRC-1:0]           unitReady;
    logic                     validBroadcast;
    logic [ROB:0]             robEntry;
    logic signed [WIDTH:0]    result;
    logic [1:0]               broadcastSrc;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cdb_broadcast_arbiter #(
        .WIDTH (WIDTH),
        .ROB   (ROB),
        .SRC   (SRC),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .globalResetN   (globalResetN),
        .clear          (clear),
        .validCommit    (validCommit),
        .unitValid      (unitValid),
        .unitRob        (unitRob),
        .unitResult     (unitResult),
        .unitReady      (unitReady),
        .validBroadcast (validBroadcast),
        .robEntry       (robEntry),
        .result         (result),
        .broadcastSrc   (broadcastSrc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: per-source expected queues ----------------
    cdb_entry_t       mq [SRC][$];
    cdb_entry_t       m_inc [SRC];
    cdb_entry_t       m_e;
    int               m_rr, m_w, m_src, m_max1;
    bit               m_byp, m_fl;
    logic             m_valid;
    logic [ROB:0]     m_rob;
    logic signed [WIDTH:0] m_res;
    logic [SRC-1:0]   m_acc;
    logic [SRC-1:0]   m_ready_v;

    always @(posedge clk or negedge globalResetN) begin
        if (!globalResetN) begin
            for (int i = 0; i < SRC; i++) mq[i].delete();
            m_rr = 0; m_valid = 1'b0; m_rob = '0; m_res = '0; m_src = 0; m_acc = '0;
        end else begin
            m_fl  = clear && validCommit;
            m_acc = '0;
            if (m_fl) begin
                for (int i = 0; i < SRC; i++) mq[i].delete();
                m_valid = 1'b0;
            end else begin
                for (int i = 0; i < SRC; i++) begin
                    m_inc[i].rob    = unitRob[i*(ROB+1) +: ROB+1];
                    m_inc[i].result = unitResult[i*(WIDTH+1) +: WIDTH+1];
                    m_acc[i]        = unitValid[i] && (mq[i].size() < DEPTH);
                end
                m_w = -1;
                for (int k = 0; k < SRC; k++) begin
                    if (m_w < 0 && (mq[(m_rr + k) % SRC].size() > 0 || (BYP && m_acc[(m_rr + k) % SRC])))
                        m_w = (m_rr + k) % SRC;
                end
                m_byp = 1'b0;
                if (m_w >= 0) begin
                    if (mq[m_w].size() > 0) m_e = mq[m_w].pop_front();
                    else begin
                        m_e   = m_inc[m_w];
                        m_byp = 1'b1;
                    end
                    m_valid = 1'b1; m_rob = m_e.rob; m_res = m_e.result; m_src = m_w;
                    m_rr = (m_w + 1) % SRC;
                end else begin
                    m_valid = 1'b0;
                end
                for (int i = 0; i < SRC; i++)
                    if (m_acc[i] && !(m_byp && m_w == i)) mq[i].push_back(m_inc[i]);
                if (mq[1].size() > m_max1) m_max1 = mq[1].size();
            end
        end
    end

    // Compare process: every cycle out of reset, away from the active edge.
    always @(negedge clk) begin
        if (globalResetN) begin
            for (int i = 0; i < SRC; i++)
                m_ready_v[i] = (mq[i].size() < DEPTH) && !(clear && validCommit);
            check("model_ready", unitReady, m_ready_v);
            check("model_valid", validBroadcast, m_valid);
            check("model_rob", robEntry, m_rob);
            check("model_result", $unsigned(result), $unsigned(m_res));
            check("model_src", broadcastSrc, m_src);
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        unitValid = '0; clear = 1'b0; validCommit = 1'b0;
    endtask

    task automatic set_unit(input int i, input logic [ROB:0] rob, input logic [WIDTH:0] res);
        unitValid[i] = 1'b1;
        unitRob[i*(ROB+1) +: ROB+1]       = rob;
        unitResult[i*(WIDTH+1) +: WIDTH+1] = res;
    endtask

    task automatic check_bus(input string name, input logic v, input logic [ROB:0] rob,
                             input logic [WIDTH:0] res, input logic [1:0] src);
        check({name, "_valid"}, validBroadcast, v);
        if (v) begin
            check({name, "_rob"}, robEntry, rob);
            check({name, "_result"}, $unsigned(result), res);
            check({name, "_src"}, broadcastSrc, src);
        end
    endtask

    task automatic run_traffic(input int cycles, input int rate, input int clr_rate,
                               input int lim0, input int lim1, input int lim2);
        int sent [SRC];
        int lim [SRC];
        logic [31:0] rv;
        sent = '{default: 0};
        lim[0] = lim0; lim[1] = lim1; lim[2] = lim2;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < SRC; i++) begin
                if (unitValid[i] && m_acc[i]) begin
                    sent[i]++;
                    unitValid[i] = 1'b0;
                end
                if (!unitValid[i] && sent[i] < lim[i] && $urandom_range(0, 99) < rate) begin
                    rv = $urandom;
                    set_unit(i, rv[ROB:0], $urandom);
                end
            end
            clear       = ($urandom_range(0, 99) < clr_rate);
            validCommit = ($urandom_range(0, 3) != 0);
            step();
        end
        clear = 1'b0; validCommit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < SRC; i++) if (unitValid[i] && m_acc[i]) unitValid[i] = 1'b0;
            if (unitValid == '0) break;
            step();
        end
        for (int i = 0; i < SRC; i++) if (unitValid[i] && m_acc[i]) unitValid[i] = 1'b0;
        check("drain_done", unitValid, '0);
        repeat (6) step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        globalResetN = 1'b0; unitRob = '0; unitResult = '0; m_max1 = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #2 globalResetN = 1'b1;
        #1;
        check_bus("reset", 1'b0, '0, '0, '0);
        check("reset_rob", robEntry, '0);
        check("reset_result", $unsigned(result), '0);
        check("reset_src", broadcastSrc, '0);
        check("reset_ready", unitReady, 3'b111);
        step();

        // Single ALU result.
        set_unit(SRC_ALU, 3'd3, 32'h0000_00AA);
        step();
        idle_inputs();
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            check_bus("alu_single", c == LAT, 3'd3, 32'h0000_00AA, 2'd0);
        end
        step();

        // Memory unit alone with a negative result.
        set_unit(SRC_MEM, 3'd5, 32'hFFFF_FFFF);
        step();
        idle_inputs();
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            check_bus("mem_single", c == LAT, 3'd5, 32'hFFFF_FFFF, 2'd2);
        end
        step();

        // All three at once: broadcasts in order 0,1,2 on consecutive cycles.
        set_unit(SRC_ALU, 3'd1, 32'h11);
        set_unit(SRC_BRANCH, 3'd2, 32'h22);
        set_unit(SRC_MEM, 3'd4, 32'h44);
        step();
        idle_inputs();
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            if (c == LAT)          check_bus("all3_0", 1'b1, 3'd1, 32'h11, 2'd0);
            else if (c == LAT + 1) check_bus("all3_1", 1'b1, 3'd2, 32'h22, 2'd1);
            else if (c == LAT + 2) check_bus("all3_2", 1'b1, 3'd4, 32'h44, 2'd2);
            else                   check_bus("all3_idle", 1'b0, '0, '0, '0);
        end
        step();

        // Pointer back at 0: ALU wins over branch.
        set_unit(SRC_BRANCH, 3'd6, 32'h66);
        set_unit(SRC_ALU, 3'd7, 32'h77);
        step();
        idle_inputs();
        for (int c = 1; c <= LAT; c++) @(negedge clk);
        check_bus("rr_zero", 1'b1, 3'd7, 32'h77, 2'd0);
        repeat (4) step();

        // clear without validCommit is ignored.
        set_unit(SRC_ALU, 3'd1, 32'h101);
        set_unit(SRC_BRANCH, 3'd2, 32'h102);
        step();
        set_unit(SRC_ALU, 3'd3, 32'h103);
        set_unit(SRC_BRANCH, 3'd4, 32'h104);
        step();
        idle_inputs();
        clear = 1'b1;
        step();
        @(negedge clk);
        check("nocommit_valid", validBroadcast, 1'b1);
        step();
        idle_inputs();
        repeat (4) step();

        // Real flush with buffers loaded and a result presented in the flush cycle.
        set_unit(SRC_ALU, 3'd5, 32'h201);
        set_unit(SRC_BRANCH, 3'd6, 32'h202);
        step();
        set_unit(SRC_ALU, 3'd7, 32'h203);
        set_unit(SRC_BRANCH, 3'd0, 32'h204);
        step();
        set_unit(SRC_ALU, 3'd2, 32'h205);
        set_unit(SRC_BRANCH, 3'd3, 32'h206);
        clear = 1'b1; validCommit = 1'b1;
        @(negedge clk);
        check("flush_ready_low", unitReady, 3'b000);
        step();
        idle_inputs();
        @(negedge clk);
        check("flush_valid", validBroadcast, 1'b0);
        check("flush_ready", unitReady, 3'b111);
        repeat (3) step();
        @(negedge clk);
        check("flush_no_stale", validBroadcast, 1'b0);
        step();

        // Asynchronous reset while a broadcast is on the bus.
        set_unit(SRC_ALU, 3'd4, 32'h301);
        step();
        idle_inputs();
        if (!BYP) step();
        check("prereset_valid", validBroadcast, 1'b1);
        #2 globalResetN = 1'b0;
        #1;
        check("async_valid", validBroadcast, 1'b0);
        check("async_rob", robEntry, '0);
        check("async_result", $unsigned(result), '0);
        check("async_src", broadcastSrc, '0);
        @(negedge clk);
        #2 globalResetN = 1'b1;
        step();

        // Branch pushes 3 results against continuous ALU traffic; branch buffer fills.
        m_max1 = 0;
        run_traffic(12, 100, 0, 8, 3, 0);
        check("branch_full_seen", m_max1, DEPTH);

        // Randomized traffic with occasional flushes.
        run_traffic(1500, 60, 3, 100000, 100000, 100000);
        run_traffic(300, 95, 0, 100000, 100000, 100000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
